// File: rtl/result_packer.sv
// Write-side packer: pairs 32-bit sums into 64-bit SRAM words (first sum low,
// second high) and writes them to a programmed, wrapping address window.
module result_packer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int ADDR_W        = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        write_base_addr_i,
  input  logic [ADDR_W-1:0]        write_end_addr_i,
  input  logic                     sum_valid_i,
  input  logic [DATA_W-1:0]        sum_data_i,
  output logic                     sum_ready_o,
  input  logic                     flush_i,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [MEM_WORD_SIZE-1:0] mem_wdata_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_END} state_t;
  typedef enum logic {LOWER, UPPER} loc_t;

  state_t                   r_state;
  loc_t                     r_loc;
  logic [MEM_WORD_SIZE-1:0] r_buf;
  logic [ADDR_W-1:0]        r_addr;
  logic [ADDR_W-1:0]        r_end;
  logic                     r_flush_pend;

  logic                     r_ready;
  logic                     r_we;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic [MEM_WORD_SIZE-1:0] r_mem_wdata;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_hs;
  logic                     w_full;
  logic                     w_has_data;
  loc_t                     w_loc_nxt;
  logic [MEM_WORD_SIZE-1:0] w_buf_nxt;

  // Buffer contents after this cycle's handshake; flush decisions look at this.
  always_comb begin
    w_hs      = (r_state == S_FILL) && sum_valid_i;
    w_buf_nxt = r_buf;
    w_loc_nxt = r_loc;
    w_full    = 1'b0;
    if (w_hs) begin
      if (r_loc == LOWER) begin
        w_buf_nxt[DATA_W-1:0] = sum_data_i;
        w_loc_nxt             = UPPER;
      end else begin
        w_buf_nxt[MEM_WORD_SIZE-1:DATA_W] = sum_data_i;
        w_loc_nxt                         = LOWER;
        w_full                            = 1'b1;
      end
    end
    w_has_data = w_full || (w_loc_nxt == UPPER);
  end

  // Outputs are registered alongside the state they belong to, so each one
  // changes on the same edge as the state transition that implies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_loc        <= LOWER;
      r_buf        <= '0;
      r_addr       <= '0;
      r_end        <= '0;
      r_flush_pend <= 1'b0;
      r_ready      <= 1'b0;
      r_we         <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_addr  <= write_base_addr_i;
            r_end   <= write_end_addr_i;
            r_loc   <= LOWER;
            r_buf   <= '0;
            r_state <= S_FILL;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_FILL: begin
          r_buf <= w_buf_nxt;
          r_loc <= w_loc_nxt;
          if (w_full || (flush_i && w_has_data)) begin
            r_flush_pend <= flush_i;
            r_state      <= S_WRITE;
            r_ready      <= 1'b0;
            r_we         <= 1'b1;
            r_mem_addr   <= r_addr;
            r_mem_wdata  <= w_buf_nxt;
          end else if (flush_i) begin
            r_state <= S_END;
            r_ready <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (r_flush_pend || (r_addr == r_end)) begin
            r_state <= S_END;
            r_done  <= 1'b1;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_buf   <= '0;
            r_state <= S_FILL;
            r_ready <= 1'b1;
          end
        end
        S_END: begin
          r_flush_pend <= 1'b0;
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sum_ready_o = r_ready;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: doc/result_packer.md
# result_packer

Write-side packing stage downstream of the calculator adder. Accepts 32-bit sums one at a time over a valid/ready handshake. Packs each pair into a 64-bit memory word: first sum in the LOWER half, second in the UPPER half. Issues one single-cycle SRAM write per word to sequential addresses in a programmed window, then pulses done.

## Interface
- DATA_W, 32, width of one sum
- MEM_WORD_SIZE, 64, SRAM word width (= 2*DATA_W)
- ADDR_W, 9, SRAM address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  pulse; latches the address window, begins packing
- write_base_addr_i  in  ADDR_W  first write address, sampled on start_i
- write_end_addr_i  in  ADDR_W  last write address (inclusive), sampled on start_i
- sum_valid_i  in  1  sum_data_i is valid
- sum_data_i  in  DATA_W  adder result
- sum_ready_o  out  1  packer accepts a sum this cycle
- flush_i  in  1  pulse; end of stream; write any partial word, then finish
- mem_we_o  out  1  SRAM write strobe, one cycle per word
- mem_addr_o  out  ADDR_W  SRAM write address
- mem_wdata_o  out  MEM_WORD_SIZE  SRAM write data
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on completion

## Operation
- States: IDLE, FILL, WRITE, END.
- Internal registers: word buffer (64b), half pointer loc (LOWER/UPPER), write address, end address, flush-pending flag.
- IDLE:
  - On start_i: addr <= base, end <= end_addr, loc <= LOWER, buffer <= 0, go FILL.
  - start_i is ignored in every other state.
- FILL:
  - sum_ready_o = 1.
  - Handshake (valid & ready) with loc = LOWER: buffer[31:0] <= data, loc <= UPPER.
  - Handshake with loc = UPPER: buffer[63:32] <= data, loc <= LOWER, go WRITE.
- flush_i in FILL, applied after any same-cycle handshake:
  - Buffer holds at least one sum: set flush-pending, go WRITE. Any unfilled upper half stays 0.
  - Buffer empty: go END directly, with no write.
- flush_i outside FILL is ignored.
- WRITE:
  - mem_we_o = 1, mem_addr_o = addr, mem_wdata_o = buffer; sum_ready_o = 0.
  - Next state: END if flush-pending or addr == end. Otherwise FILL, with addr <= addr + 1 (mod 2^ADDR_W) and buffer <= 0.
- END: done_o = 1, clear flush-pending, go IDLE.
- Address arithmetic:
  - Unsigned, wraps 511 -> 0.
  - end < base is legal; the window wraps through 0.
  - base == end gives exactly one word.
- Once the window is full, no further sums are accepted until the next start_i.
- All outputs decode from registered state only; none depend combinationally on inputs.
- mem_addr_o and mem_wdata_o are 0 whenever mem_we_o = 0.

## Timing
- Reset (async assert, sync release) gives:
  - state IDLE, buffer 0, loc LOWER, addr 0, flush-pending 0.
  - Outputs sum_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o all 0.
- Reset mid-operation aborts immediately: no write, no done.
- start_i at cycle N: busy_o and sum_ready_o are high from N+1.
- Second sum accepted at cycle N: mem_we_o high at N+1 for exactly one cycle, sum_ready_o low at N+1, high again at N+2 unless finishing.
- Peak throughput: 2 sums per 3 cycles.
- Final write at cycle W: done_o at W+1, busy_o low and IDLE at W+2.
- Empty flush at cycle F: done_o at F+1, no mem_we_o.
- sum_valid_i may drop at any time; the pack position holds indefinitely.

## Test plan
- Basic pack:
  - Stimulus: start (base 0x010, end 0x011), sums 1, 2, 3, 4 back-to-back.
  - Response: write 0x010 = 0x00000002_00000001, write 0x011 = 0x00000004_00000003, then done_o; sum_ready_o stays 0 after the 4th sum.
- Partial flush:
  - Stimulus: start (base 0x005, end 0x1FF), sum 0xA, then flush_i.
  - Response: single write 0x005 = 0x00000000_0000000A, then done_o.
- Simultaneous sum+flush:
  - Stimulus: sum 0x11 accepted (LOWER filled), then sum 0x22 with flush_i in the same cycle.
  - Response: one write of 0x00000022_00000011, done_o next cycle.
- Empty flush and ignored start:
  - Stimulus: flush_i in FILL with nothing buffered; start_i pulsed while busy.
  - Response: no mem_we_o, done_o 1 cycle later; the address window is unchanged by the busy start.
- Wrap and backpressure:
  - Stimulus: base 0x1FF, end 0x000, four sums with random valid gaps.
  - Response: writes to 0x1FF then 0x000 with the correct pairing, then done_o.
- Reset mid-stream:
  - Stimulus: assert rst after 1 sum accepted, then restart with base 0x020 and two sums.
  - Response: all outputs 0 immediately, no stray write; the new run writes only 0x020.
